// File: rtl/weighted_rr_arbiter.sv
// weighted_rr_arbiter: weighted round-robin arbiter with a rotating head pointer.
// A requester may take up to its weight in consecutive grants before the head
// moves past it. A weight field of 0 is treated as 1.
// Optional grant locking is built only when WEIGHTED_RR_ARBITER_LOCK_EN is
// defined. Without it, lock_i is ignored and the arbiter never leaves ARB.
module weighted_rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int WEIGHT_W = 4
) (
  input  logic                        clk_i,
  input  logic                        arst_ni,
  input  logic                        allow_i,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [NUM_REQ*WEIGHT_W-1:0] weight_i,
  input  logic                        lock_i,
  output logic [NUM_REQ-1:0]          gnt_o,
  output logic                        gnt_found_o,
  output logic [$clog2(NUM_REQ)-1:0]  gnt_idx_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Head pointer and the number of grants already used in the current burst.
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [WEIGHT_W-1:0] cnt_q, cnt_d;

`ifdef WEIGHTED_RR_ARBITER_LOCK_EN
  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] lidx_q, lidx_d;
`else
  // Lock input has no function in this build.
  logic unused_lock;
  assign unused_lock = lock_i;
`endif

  // Requests are forced to zero while reset is asserted, so the outputs are
  // quiet during reset even though they are combinational.
  logic [NUM_REQ-1:0] req_eff;
  assign req_eff = arst_ni ? req_i : '0;

  // Effective weight per requester: a field of 0 counts as 1.
  logic [WEIGHT_W-1:0] w_eff [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_weight
    assign w_eff[gi] = (weight_i[gi*WEIGHT_W +: WEIGHT_W] == '0)
                       ? WEIGHT_W'(1)
                       : weight_i[gi*WEIGHT_W +: WEIGHT_W];
  end

  // Rotating-priority search starting at ptr_q. Walking the offsets from high
  // to low leaves the nearest requester as the last assignment.
  logic             arb_found;
  logic [IDX_W-1:0] arb_idx;

  // Find the first active requester at or after the head pointer.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = int'(ptr_q) + off;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = IDX_W'(cand);
      if (req_eff[cand_idx]) begin
        arb_found = 1'b1;
        arb_idx   = cand_idx;
      end
    end
  end

  // Burst accounting for an ARB grant: the grant continues the burst only
  // when it goes to the requester already at the head.
  logic [WEIGHT_W:0] used;
  logic              burst_done;
  logic [IDX_W-1:0]  ptr_adv;

  // Count the grants used in the burst and decide whether the head moves on.
  always_comb begin
    used       = (arb_idx == ptr_q) ? ({1'b0, cnt_q} + (WEIGHT_W+1)'(1))
                                    : (WEIGHT_W+1)'(1);
    burst_done = (used >= {1'b0, w_eff[arb_idx]});
    ptr_adv    = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : (arb_idx + IDX_W'(1));
  end

  // Grant selection: the locked requester while locked, otherwise the search.
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;

  // Select the granted requester for this cycle.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
`ifdef WEIGHTED_RR_ARBITER_LOCK_EN
    if (state_q == ST_LOCKED) begin
      gnt_valid = allow_i & req_eff[lidx_q];
      gnt_idx   = lidx_q;
    end else begin
      gnt_valid = allow_i & arb_found;
      gnt_idx   = arb_idx;
    end
`else
    gnt_valid = allow_i & arb_found;
    gnt_idx   = arb_idx;
`endif
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
    assign gnt_o[gi] = gnt_valid && (gnt_idx == IDX_W'(gi));
  end

  assign gnt_found_o = gnt_valid;
  assign gnt_idx_o   = gnt_valid ? gnt_idx : '0;

  // Next-state logic. A low allow_i freezes every piece of state.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
`ifdef WEIGHTED_RR_ARBITER_LOCK_EN
    state_d = state_q;
    lidx_d  = lidx_q;
    if (allow_i) begin
      if (state_q == ST_LOCKED) begin
        // Leave the lock when the holder drops its request, or after a held
        // grant on a cycle where lock_i has been released.
        if (!req_eff[lidx_q] || !lock_i) begin
          state_d = ST_ARB;
        end
      end else if (arb_found) begin
        if (burst_done) begin
          ptr_d = ptr_adv;
          cnt_d = '0;
        end else begin
          ptr_d = arb_idx;
          cnt_d = used[WEIGHT_W-1:0];
        end
        if (lock_i) begin
          state_d = ST_LOCKED;
          lidx_d  = arb_idx;
        end
      end
    end
`else
    if (allow_i && arb_found) begin
      if (burst_done) begin
        ptr_d = ptr_adv;
        cnt_d = '0;
      end else begin
        ptr_d = arb_idx;
        cnt_d = used[WEIGHT_W-1:0];
      end
    end
`endif
  end

  // State registers. Reset abandons any burst or lock in progress.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef WEIGHTED_RR_ARBITER_LOCK_EN
  // Lock state registers.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= ST_ARB;
      lidx_q  <= '0;
    end else begin
      state_q <= state_d;
      lidx_q  <= lidx_d;
    end
  end
`endif

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Testbench for weighted_rr_arbiter (NUM_REQ=4, WEIGHT_W=4).
// Directed sequences plus randomized stimulus checked against a behavioural model.
module tb_weighted_rr_arbiter;

  localparam int N = 4;

  logic        clk_i = 1'b0;
  logic        arst_ni = 1'b0;
  logic        allow_i = 1'b0;
  logic [3:0]  req_i = '0;
  logic [15:0] weight_i = '0;
  logic        lock_i = 1'b0;
  logic [3:0]  gnt_o;
  logic        gnt_found_o;
  logic [1:0]  gnt_idx_o;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state
  int m_ptr    = 0;
  int m_cnt    = 0;
  int m_lidx   = 0;
  bit m_locked = 1'b0;

  weighted_rr_arbiter #(.NUM_REQ(4), .WEIGHT_W(4)) dut (
    .clk_i       (clk_i),
    .arst_ni     (arst_ni),
    .allow_i     (allow_i),
    .req_i       (req_i),
    .weight_i    (weight_i),
    .lock_i      (lock_i),
    .gnt_o       (gnt_o),
    .gnt_found_o (gnt_found_o),
    .gnt_idx_o   (gnt_idx_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit req_bit(input logic [3:0] req, input int idx);
    return ((req >> idx) & 4'b0001) != 4'b0000;
  endfunction

  // Drive one cycle, predict the grant from the model, compare, advance the model.
  // exp_idx: -2 = no directed expectation, -1 = no grant, otherwise granted index.
  task automatic apply(input logic rst, input logic [3:0] req, input logic [15:0] wt,
                       input logic allow, input logic lock, input int exp_idx);
    bit found;
    int k, w, used, c;
    @(negedge clk_i);
    arst_ni  = rst;
    req_i    = req;
    weight_i = wt;
    allow_i  = allow;
    lock_i   = lock;
    #1;
    found = 1'b0;
    k     = 0;
    if (!rst) begin
      m_ptr = 0; m_cnt = 0; m_locked = 1'b0; m_lidx = 0;
    end else if (allow) begin
      if (m_locked) begin
        if (req_bit(req, m_lidx)) begin
          found = 1'b1;
          k     = m_lidx;
          if (!lock) m_locked = 1'b0;
        end else begin
          m_locked = 1'b0;
        end
      end else begin
        for (int o = 0; o < N; o++) begin
          c = (m_ptr + o) % N;
          if (!found && req_bit(req, c)) begin
            found = 1'b1;
            k     = c;
          end
        end
        if (found) begin
          w = int'((wt >> (k * 4)) & 16'h000F);
          if (w == 0) w = 1;
          used = (k == m_ptr) ? m_cnt + 1 : 1;
          if (used >= w) begin
            m_ptr = (k + 1) % N;
            m_cnt = 0;
          end else begin
            m_ptr = k;
            m_cnt = used;
          end
`ifdef WEIGHTED_RR_ARBITER_LOCK_EN
          if (lock) begin
            m_locked = 1'b1;
            m_lidx   = k;
          end
`endif
        end
      end
    end
    check_val("gnt_o", int'(gnt_o), found ? (1 << k) : 0);
    check_val("gnt_found_o", int'(gnt_found_o), int'(found));
    check_val("gnt_idx_o", int'(gnt_idx_o), found ? k : 0);
    if (exp_idx != -2)
      check_val("seq_idx", gnt_found_o ? int'(gnt_idx_o) : -1, exp_idx);
  endtask

  task automatic do_reset();
    apply(1'b0, 4'hF, 16'h3121, 1'b1, 1'b0, -1);
    apply(1'b0, 4'hF, 16'h3121, 1'b1, 1'b0, -1);
  endtask

  int seq30 [10] = '{0, 1, 1, 2, 3, 3, 3, 0, 1, 1};

  initial begin
    // Reset state: requests gated, outputs zero
    do_reset();

    // Weighted sequence with all requesting
    for (int i = 0; i < 10; i++)
      apply(1'b1, 4'hF, 16'h3121, 1'b1, 1'b0, seq30[i]);

    // Single requester, all weights zero (treated as 1)
    do_reset();
    for (int i = 0; i < 4; i++)
      apply(1'b1, 4'b0100, 16'h0000, 1'b1, 1'b0, 2);

    // allow_i low for 5 cycles after the first grant to 1
    do_reset();
    apply(1'b1, 4'hF, 16'h3121, 1'b1, 1'b0, 0);
    apply(1'b1, 4'hF, 16'h3121, 1'b1, 1'b0, 1);
    for (int i = 0; i < 5; i++)
      apply(1'b1, 4'hF, 16'h3121, 1'b0, 1'b0, -1);
    apply(1'b1, 4'hF, 16'h3121, 1'b1, 1'b0, 1);
    apply(1'b1, 4'hF, 16'h3121, 1'b1, 1'b0, 2);
    apply(1'b1, 4'hF, 16'h3121, 1'b1, 1'b0, 3);
    apply(1'b1, 4'hF, 16'h3121, 1'b1, 1'b0, 3);
    apply(1'b1, 4'hF, 16'h3121, 1'b1, 1'b0, 3);
    apply(1'b1, 4'hF, 16'h3121, 1'b1, 1'b0, 0);

    // Reset pulsed mid-burst of requester 3
    do_reset();
    for (int i = 0; i < 6; i++)
      apply(1'b1, 4'hF, 16'h3121, 1'b1, 1'b0, seq30[i]);
    apply(1'b0, 4'hF, 16'h3121, 1'b1, 1'b0, -1);
    apply(1'b0, 4'hF, 16'h3121, 1'b1, 1'b0, -1);
    apply(1'b1, 4'hF, 16'h3121, 1'b1, 1'b0, 0);
    apply(1'b1, 4'hF, 16'h3121, 1'b1, 1'b0, 1);

`ifdef WEIGHTED_RR_ARBITER_LOCK_EN
    // Lock held for three cycles starting at a grant to 1
    do_reset();
    apply(1'b1, 4'hF, 16'h1111, 1'b1, 1'b0, 0);
    apply(1'b1, 4'hF, 16'h1111, 1'b1, 1'b1, 1);
    apply(1'b1, 4'hF, 16'h1111, 1'b1, 1'b1, 1);
    apply(1'b1, 4'hF, 16'h1111, 1'b1, 1'b1, 1);
    apply(1'b1, 4'hF, 16'h1111, 1'b1, 1'b0, 1);
    apply(1'b1, 4'hF, 16'h1111, 1'b1, 1'b0, 2);

    // Locked on 3, then its request drops
    do_reset();
    apply(1'b1, 4'hF, 16'h1111, 1'b1, 1'b0, 0);
    apply(1'b1, 4'hF, 16'h1111, 1'b1, 1'b0, 1);
    apply(1'b1, 4'hF, 16'h1111, 1'b1, 1'b0, 2);
    apply(1'b1, 4'hF, 16'h1111, 1'b1, 1'b1, 3);
    apply(1'b1, 4'hF, 16'h1111, 1'b1, 1'b1, 3);
    apply(1'b1, 4'b0111, 16'h1111, 1'b1, 1'b1, -1);
    apply(1'b1, 4'hF, 16'h1111, 1'b1, 1'b0, 0);
`else
    // Lock input has no effect in this build
    do_reset();
    apply(1'b1, 4'hF, 16'h1111, 1'b1, 1'b1, 0);
    apply(1'b1, 4'hF, 16'h1111, 1'b1, 1'b1, 1);
    apply(1'b1, 4'hF, 16'h1111, 1'b1, 1'b1, 2);
`endif

    // Randomized stimulus against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic        r_rst;
      logic [3:0]  r_req;
      logic [15:0] r_wt;
      logic        r_allow;
      logic        r_lock;
      r_rst   = ($urandom_range(0, 59) != 0);
      r_req   = 4'($urandom);
      r_wt    = (i % 40 < 20) ? 16'h3121 : 16'($urandom);
      r_allow = ($urandom_range(0, 7) != 0);
      r_lock  = ($urandom_range(0, 3) == 0);
      apply(r_rst, r_req, r_wt, r_allow, r_lock, -2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/weighted_rr_arbiter.md
WEIGHTED_RR_ARBITER -- requirements
Module: weighted_rr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters (>=2).
REQ-002 Parameter WEIGHT_W, default 4, width of each per-requester weight field.
REQ-003 clk_i  input  1  clock; all state updates on its rising edge.
REQ-004 arst_ni  input  1  reset, asynchronous, active-low.
REQ-005 allow_i  input  1  arbitration enable; low suppresses all grants.
REQ-006 req_i  input  NUM_REQ  request vector, bit k = requester k.
REQ-007 weight_i  input  NUM_REQ*WEIGHT_W  packed weights, field k = bits [k*WEIGHT_W +: WEIGHT_W].
REQ-008 lock_i  input  1  hold current grant into the next cycle.
REQ-009 gnt_o  output  NUM_REQ  one-hot grant vector, or zero.
REQ-010 gnt_found_o  output  1  high when gnt_o is non-zero.
REQ-011 gnt_idx_o  output  $clog2(NUM_REQ)  index of granted requester; 0 when gnt_found_o is low.

Function
REQ-012 Grant SHALL be combinational from req_i, allow_i and current state (zero-cycle latency); state SHALL update on the clock edge after a grant cycle.
REQ-013 State: head pointer ptr (0..NUM_REQ-1), burst counter cnt (WEIGHT_W bits), FSM {ARB, LOCKED}, locked index lidx.
REQ-014 ARB: grant the first requester k with req_i[k]=1, searching ptr, ptr+1, ... modulo NUM_REQ.
REQ-015 Effective weight w_k = weight field k, with value 0 treated as 1; weight is sampled on every grant cycle.
REQ-016 On an ARB grant to k: used = (k==ptr) ? cnt+1 : 1.
REQ-017 If used >= w_k, then ptr <= (k+1) mod NUM_REQ and cnt <= 0.
REQ-018 Otherwise ptr <= k and cnt <= used.
REQ-019 A weight lowered mid-burst below the consumed count SHALL cause the pointer to advance at the next grant to that requester.
REQ-020 ARB grant with lock_i=1 SHALL move the FSM to LOCKED with lidx <= k; ptr and cnt update as in REQ-016 to REQ-018.
REQ-021 LOCKED: gnt_o = onehot(lidx) while req_i[lidx]=1 and allow_i=1, regardless of other requests; ptr and cnt SHALL NOT change.
REQ-022 LOCKED exit to ARB: on a cycle where lock_i=0 and the grant is held, or when req_i[lidx]=0 (no grant that cycle; arbitration resumes on the next cycle).
REQ-023 allow_i=0: gnt_o=0 and gnt_found_o=0; ptr, cnt, FSM state and lidx held.
REQ-024 No requests in ARB: zero outputs; state held.
REQ-025 At most one gnt_o bit SHALL be high in any cycle.

Reset
REQ-026 While arst_ni=0: ptr=0, cnt=0, FSM=ARB, lidx=0; req_i internally gated to zero so gnt_o=0, gnt_found_o=0, gnt_idx_o=0.
REQ-027 Reset asserted mid-burst or mid-lock SHALL abandon the burst or lock; the first grant after release is searched from index 0.

Configuration
REQ-028 Macro WEIGHTED_RR_ARBITER_LOCK_EN defined: lock_i and the LOCKED state behave as in REQ-020 to REQ-022.
REQ-029 Macro not defined: lock_i SHALL be ignored, the FSM SHALL remain in ARB permanently, and no LOCKED or lidx logic SHALL be built.

Verification (NUM_REQ=4, WEIGHT_W=4)
REQ-030 req_i=4'b1111, weights {w0=1, w1=2, w2=1, w3=3}, allow_i=1, lock_i=0 -> gnt_idx_o sequence 0,1,1,2,3,3,3,0,1,1,...
REQ-031 req_i=4'b0100 constant, all weights 0 -> gnt_o=4'b0100 every cycle; ptr toggles to 3 after each grant.
REQ-032 Scenario of REQ-030 with allow_i=0 for 5 cycles after the first grant to 1 -> 5 cycles of gnt_o=0, then 1,2,3,... resumes unchanged.
REQ-033 LOCK_EN defined, all requesting, weights 1, lock_i=1 for 3 cycles starting at a grant to 1 -> gnt_o=4'b0010 for 4 cycles, then grant 2.
REQ-034 LOCK_EN defined, locked on index 3, then req_i[3] drops -> gnt_o=0 that cycle; next cycle arbitration from ptr=0 grants 0.
REQ-035 arst_ni pulsed low mid-burst of w3=3 (after the second grant to 3) -> outputs 0 during reset; after release with all requesting, first grant is 0.
